// File: rtl/pixel_pingpong_mem.sv
// pixel_pingpong_mem
//   Multi-bank (ping-pong) pixel store that sits between an image writer
//   and a pixel reader. The writer fills the bank at wr_bank while the
//   reader drains the bank at rd_bank. A wr_done pulse hands the current
//   write bank to the reader, and a rd_done pulse hands the current read
//   bank back to the writer. full_cnt counts banks that are waiting for or
//   owned by the reader. While both sides are ready the two pointers name
//   different banks, so a read and a write never touch the same bank.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data        pixel write into the current write bank
//   wr_done                        close write bank and pass it to the reader
//   wr_ready                       writer owns a free bank
//   rd_en, rd_addr                 pixel read from the current read bank
//   rd_done                        release read bank back to the writer
//   rd_ready                       reader owns a full bank
//   rd_data, rd_valid              registered read data (1-cycle latency)
//   wr_bank, rd_bank               current bank indices
//   full_cnt                       number of full banks
//   err                            sticky protocol error, cleared by rst
module pixel_pingpong_mem #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int NUM_BANKS = 2,
  localparam int PTR_W    = $clog2(NUM_BANKS),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_done,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [PTR_W-1:0]  wr_bank,
  output logic [PTR_W-1:0]  rd_bank,
  output logic [CNT_W-1:0]  full_cnt,
  output logic              err
);

  // All banks live in one flat array; bank b occupies words
  // [b*DEPTH, (b+1)*DEPTH). This keeps non-power-of-2 bank counts and
  // depths free of unused address holes.
  localparam int MEM_WORDS = NUM_BANKS * DEPTH;
  localparam int MEM_AW    = $clog2(MEM_WORDS);

  localparam logic [CNT_W-1:0]  BANKS_C   = CNT_W'(NUM_BANKS);
  localparam logic [PTR_W-1:0]  LAST_BANK = PTR_W'(NUM_BANKS - 1);
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic [PTR_W-1:0]  wr_bank_reg,  wr_bank_next;
  logic [PTR_W-1:0]  rd_bank_reg,  rd_bank_next;
  logic [CNT_W-1:0]  full_cnt_reg, full_cnt_next;
  logic              err_reg,      err_next;
  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_valid_reg;

  logic              wr_addr_ok, rd_addr_ok;
  logic              wr_fire, rd_fire;
  logic              wr_adv, rd_adv;
  logic              err_set;
  logic [MEM_AW-1:0] wr_idx, rd_idx;

  assign wr_ready = (full_cnt_reg < BANKS_C);
  assign rd_ready = (full_cnt_reg != '0);

  assign wr_addr_ok = ({1'b0, wr_addr} < DEPTH_C);
  assign rd_addr_ok = ({1'b0, rd_addr} < DEPTH_C);

  assign wr_fire = wr_en & wr_ready & wr_addr_ok;
  assign rd_fire = rd_en & rd_ready & rd_addr_ok;
  assign wr_adv  = wr_done & wr_ready;
  assign rd_adv  = rd_done & rd_ready;

  // Any request the current ownership or address range cannot honour.
  // The offending operation is simply not performed.
  assign err_set = ((wr_en | wr_done) & ~wr_ready)
                 | ((rd_en | rd_done) & ~rd_ready)
                 | (wr_en & ~wr_addr_ok)
                 | (rd_en & ~rd_addr_ok);

  // Addresses are only used when in range, so truncation here is harmless.
  assign wr_idx = MEM_AW'(wr_bank_reg) * MEM_AW'(DEPTH) + MEM_AW'(wr_addr);
  assign rd_idx = MEM_AW'(rd_bank_reg) * MEM_AW'(DEPTH) + MEM_AW'(rd_addr);

  always_comb begin
    wr_bank_next  = wr_bank_reg;
    rd_bank_next  = rd_bank_reg;
    full_cnt_next = full_cnt_reg;
    err_next      = err_reg | err_set;

    if (wr_adv)
      wr_bank_next = (wr_bank_reg == LAST_BANK) ? '0 : wr_bank_reg + PTR_W'(1);
    if (rd_adv)
      rd_bank_next = (rd_bank_reg == LAST_BANK) ? '0 : rd_bank_reg + PTR_W'(1);

    // Simultaneous hand-over in both directions leaves the count unchanged.
    case ({wr_adv, rd_adv})
      2'b10:   full_cnt_next = full_cnt_reg + CNT_W'(1);
      2'b01:   full_cnt_next = full_cnt_reg - CNT_W'(1);
      default: full_cnt_next = full_cnt_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_reg  <= '0;
      rd_bank_reg  <= '0;
      full_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      wr_bank_reg  <= wr_bank_next;
      rd_bank_reg  <= rd_bank_next;
      full_cnt_reg <= full_cnt_next;
      err_reg      <= err_next;
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_idx] <= wr_data;
  end

  // Registered read port. rd_data holds its last value when no read fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_fire;
      if (rd_fire)
        rd_data_reg <= mem[rd_idx];
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign wr_bank  = wr_bank_reg;
  assign rd_bank  = rd_bank_reg;
  assign full_cnt = full_cnt_reg;
  assign err      = err_reg;

endmodule
